// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and FSM state type for the RAM burst reader
// Contents:
//   RAM_ADDR_W / RAM_DATA_W : default geometry of the 64x8 dual-port RAM
//   RAM_DEPTH               : number of RAM words
//   FIFO_DEPTH              : entries in the read-data FIFO (also the read credit limit)
//   state_t                 : burst reader FSM states
package ram_pkg;

  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// rtl/ram_burst_reader_if.sv - command, RAM read port and output stream bundle
// Signals:
//   start, base_addr, len, busy, done          : burst command / status
//   ram_addr, ram_rd, ram_q                    : RAM read port (q valid the cycle after rd)
//   out_data, out_valid, out_ready, out_last   : output word stream
// Modports:
//   master : the burst reader
//   slave  : the surrounding logic (command source, RAM, consumer)
interface ram_burst_reader_if
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [DATA_W-1:0] ram_q;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  start, base_addr, len, ram_q, out_ready,
    output busy, done, ram_addr, ram_rd, out_data, out_valid, out_last
  );

  modport slave (
    output start, base_addr, len, ram_q, out_ready,
    input  busy, done, ram_addr, ram_rd, out_data, out_valid, out_last
  );

endinterface

// File: rtl/ram_rd_fifo2.sv
// rtl/ram_rd_fifo2.sv - two-entry synchronous FIFO for returned RAM words
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   push, push_data: write an entry ({last, data} in the reader)
//   pop            : remove the head entry
//   count          : current number of entries (0..2)
//   head           : head entry contents
//   head_valid     : FIFO is non-empty
module ram_rd_fifo2
  import ram_pkg::*;
#(
  parameter int WIDTH = RAM_DATA_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head,
  output logic             head_valid
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count < 2'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (count != 2'd0);

endmodule

// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - burst read master for the 64x8 RAM with a streaming output
// Ports:
//   clock   : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : ram_burst_reader_if master modport
//             start/base_addr/len in, busy/done out
//             ram_addr/ram_rd out, ram_q in (one-cycle read latency)
//             out_data/out_valid/out_last out, out_ready in
module ram_burst_reader
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic                clock,
  input  logic                reset_n,
  ram_burst_reader_if.master  bus
);

  state_t            state;
  state_t            state_n;

  logic [ADDR_W-1:0] ram_addr;
  logic [ADDR_W:0]   remaining;
  logic              inflight;
  logic              inflight_last;
  logic              done;

  logic              accept;
  logic              accept_zero;
  logic              issue;
  logic              finish;

  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              fifo_valid;
  logic              pop;
  logic [2:0]        occupancy;
  logic              credit_ok;

  assign pop = fifo_valid && bus.out_ready;

  // Words that will occupy the FIFO after this edge if no new read is issued.
  // Issuing only while this is below the FIFO depth means every returned word
  // has a slot, so the RAM never needs to be stalled.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign credit_ok = (occupancy < 3'(FIFO_DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    accept_zero = 1'b0;
    issue       = 1'b0;
    finish      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            accept  = 1'b1;
            state_n = READ;
          end else begin
            accept_zero = 1'b1;
          end
        end
      end
      READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remaining == (ADDR_W+1)'(1)) begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!inflight && (fifo_count == 2'd0)) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= accept_zero || finish;
      inflight      <= issue;
      inflight_last <= issue && (remaining == (ADDR_W+1)'(1));
      if (accept) begin
        ram_addr  <= bus.base_addr;
        remaining <= bus.len;
      end else if (issue) begin
        // Natural ADDR_W-bit overflow gives the 63 -> 0 wrap.
        ram_addr  <= ram_addr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
    end
  end

  ram_rd_fifo2 #(
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (inflight),
    .push_data  ({inflight_last, bus.ram_q}),
    .pop        (pop),
    .count      (fifo_count),
    .head       (fifo_head),
    .head_valid (fifo_valid)
  );

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_rd    = issue;
  assign bus.out_data  = fifo_head[DATA_W-1:0];
  assign bus.out_valid = fifo_valid;
  assign bus.out_last  = fifo_valid && fifo_head[DATA_W];

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - self-checking bench for ram_burst_reader
module tb_ram_burst_reader;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  ram_burst_reader_if #(.ADDR_W(6), .DATA_W(8)) bus();

  ram_burst_reader #(
    .ADDR_W (6),
    .DATA_W (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] mem [64];

  // RAM read port: registered, one-cycle latency.
  always @(posedge clock) begin
    if (bus.ram_rd) bus.ram_q <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] exp_addr [$];
  logic [8:0] exp_beat [$];
  logic [5:0] mon_a;
  logic [8:0] mon_b;

  int  issued = 0, accepted = 0, iss_base = 0, acc_base = 0;
  int  done_cnt = 0, cyc = 0;
  int  first_beat = -1, last_beat = -1, first_rd = -1, last_rd = -1;
  bit  rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every read address and every accepted beat must match the
  // expected burst contents, in order.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.ram_rd) begin
        check("rd_expected", 32'(exp_addr.size() != 0), 32'(1));
        if (exp_addr.size() != 0) begin
          mon_a = exp_addr.pop_front();
          check("ram_addr", 32'(bus.ram_addr), 32'(mon_a));
        end
        issued++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("beat_expected", 32'(exp_beat.size() != 0), 32'(1));
        if (exp_beat.size() != 0) begin
          mon_b = exp_beat.pop_front();
          check("out_data", 32'(bus.out_data), 32'(mon_b[7:0]));
          check("out_last", 32'(bus.out_last), 32'(mon_b[8]));
        end
        accepted++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
      end
      if (bus.busy)
        check("outstanding_le2", 32'(((issued - iss_base) - (accepted - acc_base)) <= 2), 32'(1));
      if (bus.done) begin
        done_cnt++;
        check("done_busy_low", 32'(bus.busy), 32'(0));
      end
    end
    cyc++;
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_burst(input int base, input int len, input bit expect_it);
    @(posedge clock);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = 6'(base);
    bus.len       = 7'(len);
    if (expect_it) begin
      first_beat = -1;
      first_rd   = -1;
      for (int i = 0; i < len; i++) begin
        int a;
        a = (base + i) % 64;
        exp_addr.push_back(6'(a));
        exp_beat.push_back({(i == len - 1), mem[6'(a)]});
      end
    end
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
    bus.base_addr = 6'($urandom);
    bus.len       = 7'($urandom);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 600) begin
      @(posedge clock);
      n++;
    end
    check({tag, "_done"}, 32'(done_cnt == d0 + 1), 32'(1));
    check({tag, "_addrs_left"}, 32'(exp_addr.size()), 32'(0));
    check({tag, "_beats_left"}, 32'(exp_beat.size()), 32'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     32'(bus.busy),      32'(0));
    check({tag, "_done"},     32'(bus.done),      32'(0));
    check({tag, "_ram_rd"},   32'(bus.ram_rd),    32'(0));
    check({tag, "_valid"},    32'(bus.out_valid), 32'(0));
    check({tag, "_last"},     32'(bus.out_last),  32'(0));
    check({tag, "_ram_addr"}, 32'(bus.ram_addr),  32'(0));
    check({tag, "_data"},     32'(bus.out_data),  32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0, n, base, len;
    logic [7:0] held;

    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);

    // Reset held with start asserted
    reset_n = 1'b0;
    bus.start = 1'b1; bus.base_addr = 6'd3; bus.len = 7'd5;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    @(posedge clock); #1;
    bus.start = 1'b0;
    reset_n   = 1'b1;
    repeat (2) @(negedge clock);
    check("post_reset_busy", 32'(bus.busy), 32'(0));

    // Single word with latency checks
    mem[5] = 8'hFF;
    bus.out_ready = 1'b1;
    d0 = done_cnt;
    start_burst(5, 1, 1'b1);
    @(negedge clock);
    check("single_rd", 32'(bus.ram_rd), 32'(1));
    check("single_addr", 32'(bus.ram_addr), 32'(5));
    check("single_busy", 32'(bus.busy), 32'(1));
    @(negedge clock);
    check("single_rd_once", 32'(bus.ram_rd), 32'(0));
    check("single_valid_early", 32'(bus.out_valid), 32'(0));
    @(negedge clock);
    check("single_valid", 32'(bus.out_valid), 32'(1));
    check("single_data", 32'(bus.out_data), 32'(8'hFF));
    check("single_last", 32'(bus.out_last), 32'(1));
    wait_done(d0, "single");
    @(negedge clock);
    check("single_done_pulse", 32'(bus.done), 32'(0));
    check("single_busy_end", 32'(bus.busy), 32'(0));

    // Streaming with address wrap
    mem[62] = 8'hA0; mem[63] = 8'hA1; mem[0] = 8'hA2; mem[1] = 8'hA3;
    d0 = done_cnt;
    start_burst(62, 4, 1'b1);
    wait_done(d0, "wrap");
    check("wrap_rd_span", 32'(last_rd - first_rd), 32'(3));
    check("wrap_beat_span", 32'(last_beat - first_beat), 32'(3));

    // Backpressure
    for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
    d0 = done_cnt;
    start_burst(0, 6, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clock); n++; end
    check("bp_first_valid", 32'(bus.out_valid), 32'(1));
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    @(negedge clock);
    held = bus.out_data;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", 32'(bus.out_valid), 32'(1));
      check("bp_hold_data", 32'(bus.out_data), 32'(held));
      check("bp_no_read", 32'(bus.ram_rd), 32'(0));
      if (k < 4) @(negedge clock);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    wait_done(d0, "bp");

    // len = 0
    d0 = done_cnt;
    start_burst(9, 0, 1'b1);
    @(negedge clock);
    check("len0_done", 32'(bus.done), 32'(1));
    check("len0_busy", 32'(bus.busy), 32'(0));
    repeat (4) begin
      @(negedge clock);
      check("len0_no_valid", 32'(bus.out_valid), 32'(0));
    end
    check("len0_one_done", 32'(done_cnt), 32'(d0 + 1));

    // start while busy is ignored
    d0 = done_cnt;
    start_burst(10, 8, 1'b1);
    repeat (2) @(posedge clock);
    start_burst(20, 5, 1'b0);
    wait_done(d0, "ignore");
    repeat (5) @(negedge clock);
    check("ignore_idle", 32'(bus.busy), 32'(0));
    check("ignore_one_done", 32'(done_cnt), 32'(d0 + 1));

    // Reset in the middle of a burst
    d0 = done_cnt;
    a0 = accepted;
    start_burst(30, 8, 1'b1);
    n = 0;
    while (accepted < a0 + 3 && n < 50) begin @(posedge clock); n++; end
    check("mid_three_beats", 32'(accepted - a0), 32'(3));
    #1;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    exp_addr.delete();
    exp_beat.delete();
    iss_base = issued;
    acc_base = accepted;
    repeat (3) @(negedge clock);
    check("mid_no_done", 32'(done_cnt), 32'(d0));
    @(posedge clock); #1;
    reset_n = 1'b1;
    d0 = done_cnt;
    start_burst(40, 5, 1'b1);
    wait_done(d0, "after_reset");

    // Randomized bursts with random backpressure
    rand_ready = 1'b1;
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      base = $urandom_range(0, 63);
      if (b == 0)          len = 64;
      else if (b % 8 == 7) len = 0;
      else                 len = $urandom_range(1, 64);
      d0 = done_cnt;
      start_burst(base, len, 1'b1);
      wait_done(d0, "rand");
      if (len != 0) check("rand_end_addr", 32'(bus.ram_addr), 32'((base + len) % 64));
    end
    rand_ready = 1'b0;
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
